execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, single-cycle ALU, branch resolution,
// multi-cycle shift-add multiplier and the EX/MEM pipeline register.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwriteE,
    input  logic        memwriteE,
    input  logic        branchE,
    input  logic        jumpE,
    input  logic        alusrcE,
    input  logic [1:0]  resultsrcE,
    input  logic [3:0]  alucontrolE,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [31:0] immextE,
    input  logic [31:0] pcE,
    input  logic [31:0] pcplus4E,
    input  logic [4:0]  rdE,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] resultW,
    output logic        regwriteM,
    output logic        memwriteM,
    output logic [1:0]  resultsrcM,
    output logic [31:0] aluresultM,
    output logic [31:0] writedataM,
    output logic [31:0] pcplus4M,
    output logic [4:0]  rdM,
    output logic        pcsrcE,
    output logic [31:0] pctargetE,
    output logic        busyE
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_out;
    logic [31:0] result;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] prod;
    logic [4:0]  cnt;
    logic        mul_op;
    logic        zero;

    assign mul_op = (alucontrolE == 4'b1010);

    // Forwarding muxes; code 11 falls back to the register-file value.
    always_comb begin
        src_a = rd1E;
        fwd_b = rd2E;
        case (forwardAE)
            2'b01:   src_a = resultW;
            2'b10:   src_a = aluresultM;
            default: src_a = rd1E;
        endcase
        case (forwardBE)
            2'b01:   fwd_b = resultW;
            2'b10:   fwd_b = aluresultM;
            default: fwd_b = rd2E;
        endcase
    end

    assign src_b = alusrcE ? immextE : fwd_b;

    // Single-cycle ALU; MUL and undefined codes give 0 here.
    always_comb begin
        alu_out = 32'h0;
        case (alucontrolE)
            4'b0000: alu_out = src_a + src_b;
            4'b0001: alu_out = src_a - src_b;
            4'b0010: alu_out = src_a & src_b;
            4'b0011: alu_out = src_a | src_b;
            4'b0100: alu_out = src_a ^ src_b;
            4'b0101: alu_out = {31'h0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_out = src_a << src_b[4:0];
            4'b0111: alu_out = src_a >> src_b[4:0];
            4'b1000: alu_out = $signed(src_a) >>> src_b[4:0];
            4'b1001: alu_out = {31'h0, src_a < src_b};
            default: alu_out = 32'h0;
        endcase
    end

    assign zero      = (alu_out == 32'h0);
    assign pctargetE = pcE + immextE;
    assign pcsrcE    = (branchE & zero) | jumpE;
    assign result    = (state == DONE) ? prod : alu_out;

    // Multiplier next state and stall request.
    always_comb begin
        state_nx = state;
        busyE    = 1'b0;
        case (state)
            IDLE: begin
                busyE = mul_op;
                if (mul_op)
                    state_nx = RUN;
            end
            RUN: begin
                busyE = 1'b1;
                if (cnt == 5'd31)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!rst)
            busyE = 1'b0;
    end

    // Multiplier state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Shift-add datapath: operands captured once, one step per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= 32'h0;
            mplier <= 32'h0;
            prod   <= 32'h0;
            cnt    <= 5'd0;
        end else if (state == IDLE && mul_op) begin
            mcand  <= src_a;
            mplier <= src_b;
            prod   <= 32'h0;
            cnt    <= 5'd0;
        end else if (state == RUN) begin
            prod   <= prod + (mplier[0] ? mcand : 32'h0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end

    // EX/MEM register; a bubble is loaded while the multiplier stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || busyE) begin
            regwriteM  <= 1'b0;
            memwriteM  <= 1'b0;
            resultsrcM <= 2'b00;
            aluresultM <= 32'h0;
            writedataM <= 32'h0;
            pcplus4M   <= 32'h0;
            rdM        <= 5'd0;
        end else begin
            regwriteM  <= regwriteE;
            memwriteM  <= memwriteE;
            resultsrcM <= resultsrcE;
            aluresultM <= result;
            writedataM <= fwd_b;
            pcplus4M   <= pcplus4E;
            rdM        <= rdE;
        end
    end

endmodule
